// File: rtl/myca_plant_model.sv
// ============================================================================
// Module      : myca_plant_model
// Description : Cycle-level tank process emulator for the MYCA II controller.
//               Consumes SV/CL/CN/DE commands and produces the M, SL, SG,
//               LS, LC and SE sensor flags. Process state advances on tick.
//               Optional macro PLANT_HYST_EN adds hysteresis to SL and SG.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module myca_plant_model #(
    parameter int LEVEL_W    = 8,
    parameter int FILL_RATE  = 4,
    parameter int DRAIN_RATE = 6,
    parameter int LOW_TH     = 32,
    parameter int HIGH_TH    = 200,
    parameter int HEAT_RATE  = 2,
    parameter int TEMP_AMB   = 25,
    parameter int TEMP_TH    = 80,
    parameter int COOL_DIV   = 4,
    parameter int MIX_TICKS  = 10,
    parameter int HYST       = 8
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               tick,
    input  logic               m_btn,
    input  logic               flt_clr,
    input  logic               SV,
    input  logic               CL,
    input  logic               CN,
    input  logic               DE,
    output logic               M,
    output logic               SL,
    output logic               SG,
    output logic               LS,
    output logic               LC,
    output logic               SE,
    output logic [LEVEL_W-1:0] level,
    output logic [LEVEL_W-1:0] temp
);

    // Signed width with headroom for both overflow above max and dips below 0.
    localparam int SW = LEVEL_W + 2;
    localparam int CW = $clog2(COOL_DIV + 1);
    localparam int MW = $clog2(MIX_TICKS + 1);

`ifdef PLANT_HYST_EN
    localparam int HYST_EFF = HYST;
`else
    // A zero-width band reduces the hysteresis logic to a plain threshold compare.
    localparam int HYST_EFF = HYST * 0;
`endif

    localparam logic signed [SW-1:0] FILL_S   = SW'(FILL_RATE);
    localparam logic signed [SW-1:0] DRAIN_S  = SW'(DRAIN_RATE);
    localparam logic signed [SW-1:0] LMAX_S   = SW'((1 << LEVEL_W) - 1);
    localparam logic [LEVEL_W-1:0]   LOW_SET  = LEVEL_W'(LOW_TH);
    localparam logic [LEVEL_W-1:0]   LOW_CLR  = LEVEL_W'(LOW_TH - HYST_EFF);
    localparam logic [LEVEL_W-1:0]   HIGH_SET = LEVEL_W'(HIGH_TH);
    localparam logic [LEVEL_W-1:0]   HIGH_CLR = LEVEL_W'(HIGH_TH - HYST_EFF);
    localparam logic [LEVEL_W-1:0]   AMB      = LEVEL_W'(TEMP_AMB);
    localparam logic [LEVEL_W-1:0]   TEMP_T   = LEVEL_W'(TEMP_TH);
    localparam logic [LEVEL_W:0]     HEAT_S   = (LEVEL_W + 1)'(HEAT_RATE);
    localparam logic [CW-1:0]        COOL_LAST = CW'(COOL_DIV - 1);
    localparam logic [MW-1:0]        MIX_MAX  = MW'(MIX_TICKS);

    logic                     sync1, sync2;
    logic [CW-1:0]            cool_cnt;
    logic [MW-1:0]            mix_cnt;
    logic signed [SW-1:0]     fill_amt, drain_amt, lvl_raw;
    logic [LEVEL_W-1:0]       lvl_clamp;
    logic [LEVEL_W:0]         heat_sum;
    logic                     over_max, overflow, dry_heat, heat_ok;

    assign M = sync2;

    // Next-level arithmetic with clamping, plus fault and heating qualifiers.
    always_comb begin
        fill_amt  = SV ? FILL_S : '0;
        drain_amt = DE ? DRAIN_S : '0;
        lvl_raw   = $signed({2'b00, level}) + fill_amt - drain_amt;
        over_max  = !lvl_raw[SW-1] && (lvl_raw > LMAX_S);
        if (lvl_raw[SW-1]) begin
            lvl_clamp = '0;
        end else if (over_max) begin
            lvl_clamp = '1;
        end else begin
            lvl_clamp = lvl_raw[LEVEL_W-1:0];
        end
        overflow = SV && over_max;
        dry_heat = CL && (level < LOW_SET);
        heat_ok  = CL && (level >= LOW_SET);
        heat_sum = {1'b0, temp} + HEAT_S;
    end

    // Plant state, button synchronizer, registered sensor flags and sticky fault.
    always_ff @(posedge ck) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            level    <= '0;
            temp     <= AMB;
            cool_cnt <= '0;
            mix_cnt  <= '0;
            SL       <= 1'b0;
            SG       <= 1'b0;
            LS       <= 1'b0;
            LC       <= 1'b0;
            SE       <= 1'b0;
        end else begin
            sync1 <= m_btn;
            sync2 <= sync1;

            if (tick) begin
                level <= lvl_clamp;
                if (heat_ok) begin
                    temp     <= heat_sum[LEVEL_W] ? '1 : heat_sum[LEVEL_W-1:0];
                    cool_cnt <= '0;
                end else if (temp > AMB) begin
                    if (cool_cnt == COOL_LAST) begin
                        temp     <= temp - 1'b1;
                        cool_cnt <= '0;
                    end else begin
                        cool_cnt <= cool_cnt + 1'b1;
                    end
                end else begin
                    cool_cnt <= '0;
                end
            end

            // Agitator count clears whenever CN drops, independent of tick.
            if (!CN) begin
                mix_cnt <= '0;
            end else if (tick && (mix_cnt != MIX_MAX)) begin
                mix_cnt <= mix_cnt + 1'b1;
            end

            // Flags follow the registered state, so they lag an update by one ck.
            if (level >= LOW_SET) begin
                SL <= 1'b1;
            end else if (level < LOW_CLR) begin
                SL <= 1'b0;
            end
            if (level >= HIGH_SET) begin
                SG <= 1'b1;
            end else if (level < HIGH_CLR) begin
                SG <= 1'b0;
            end
            LS <= (temp >= TEMP_T);
            LC <= (mix_cnt == MIX_MAX);

            // A live fault condition beats a simultaneous clear request.
            if (tick && (overflow || dry_heat)) begin
                SE <= 1'b1;
            end else if (flt_clr) begin
                SE <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_myca_plant_model.sv
// ============================================================================
// Module      : tb_myca_plant_model
// Description : Self-checking bench for myca_plant_model using a table of
//               step vectors plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_myca_plant_model;

    logic       ck = 1'b0;
    logic       rst, tick, m_btn, flt_clr, SV, CL, CN, DE;
    logic       M, SL, SG, LS, LC, SE;
    logic [7:0] level, temp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        bit    do_rst;
        bit    sv, cl, cn, de, clr;
        int    n;
        int    lvl, tmp;
        bit    sl, sg, ls, lc, se;
    } vec_t;

    vec_t vecs[$];

    always #5 ck = ~ck;

    myca_plant_model dut (
        .ck(ck), .rst(rst), .tick(tick), .m_btn(m_btn), .flt_clr(flt_clr),
        .SV(SV), .CL(CL), .CN(CN), .DE(DE),
        .M(M), .SL(SL), .SG(SG), .LS(LS), .LC(LC), .SE(SE),
        .level(level), .temp(temp)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input string name, input bit r, input bit sv, input bit cl,
                       input bit cn, input bit de, input bit clr, input int n,
                       input int lvl, input int tmp, input bit sl, input bit sg,
                       input bit ls, input bit lc, input bit se);
        vec_t v;
        v.name = name; v.do_rst = r; v.sv = sv; v.cl = cl; v.cn = cn; v.de = de;
        v.clr = clr; v.n = n; v.lvl = lvl; v.tmp = tmp;
        v.sl = sl; v.sg = sg; v.ls = ls; v.lc = lc; v.se = se;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge ck);
        rst = 1'b1; tick = 1'b0; flt_clr = 1'b0;
        SV = 1'b0; CL = 1'b0; CN = 1'b0; DE = 1'b0; m_btn = 1'b0;
        @(negedge ck);
        @(negedge ck);
        rst = 1'b0;
    endtask

    // One tick strobe followed by one idle ck; flt_clr rides only on the strobe.
    task automatic ticks(input int n, input bit clr);
        for (int i = 0; i < n; i++) begin
            @(negedge ck);
            tick = 1'b1; flt_clr = clr;
            @(negedge ck);
            tick = 1'b0; flt_clr = 1'b0;
        end
    endtask

    task automatic settle();
        @(negedge ck);
        @(negedge ck);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; m_btn = 1'b0; flt_clr = 1'b0;
        SV = 1'b0; CL = 1'b0; CN = 1'b0; DE = 1'b0;

        //   name        rst sv cl cn de clr  n   lvl tmp sl sg ls lc se
        add("fill7",      1, 1, 0, 0, 0, 0,  7,  28, 25, 0, 0, 0, 0, 0);
        add("fill8",      0, 1, 0, 0, 0, 0,  1,  32, 25, 1, 0, 0, 0, 0);
        add("fill50",     0, 1, 0, 0, 0, 0, 42, 200, 25, 1, 1, 0, 0, 0);
        add("fill63",     0, 1, 0, 0, 0, 0, 13, 252, 25, 1, 1, 0, 0, 0);
        add("ovf64",      0, 1, 0, 0, 0, 0,  1, 255, 25, 1, 1, 0, 0, 1);
        add("ovf_hold",   0, 1, 0, 0, 0, 0,  1, 255, 25, 1, 1, 0, 0, 1);
        add("flt_clr",    0, 0, 0, 0, 0, 1,  1, 255, 25, 1, 1, 0, 0, 0);
        add("heat_fill",  1, 1, 0, 0, 0, 0, 25, 100, 25, 1, 0, 0, 0, 0);
        add("heat28",     0, 0, 1, 0, 0, 0, 28, 100, 81, 1, 0, 1, 0, 0);
        add("cool4",      0, 0, 0, 0, 0, 0,  4, 100, 80, 1, 0, 1, 0, 0);
        add("cool8",      0, 0, 0, 0, 0, 0,  4, 100, 79, 1, 0, 0, 0, 0);
        add("sv_de5",     0, 1, 0, 0, 1, 0,  5,  90, 78, 1, 0, 0, 0, 0);
        add("de20",       0, 0, 0, 0, 1, 0, 20,   0, 73, 0, 0, 0, 0, 0);
        add("dry_heat",   1, 0, 1, 0, 0, 0,  1,   0, 25, 0, 0, 0, 0, 1);
        add("set_wins",   0, 0, 1, 0, 0, 1,  1,   0, 25, 0, 0, 0, 0, 1);
        add("clr_dry",    0, 0, 0, 0, 0, 1,  1,   0, 25, 0, 0, 0, 0, 0);
        add("mix9",       1, 0, 0, 1, 0, 0,  9,   0, 25, 0, 0, 0, 0, 0);
        add("mix10",      0, 0, 0, 1, 0, 0,  1,   0, 25, 0, 0, 0, 1, 0);
        add("mix_sat",    0, 0, 0, 1, 0, 0,  5,   0, 25, 0, 0, 0, 1, 0);

        // Reset state
        do_reset();
        settle();
        chk("rst_level", level, 0);
        chk("rst_temp", temp, 25);
        chk("rst_flags", {M, SL, SG, LS, LC, SE}, 0);

        foreach (vecs[k]) begin
            if (vecs[k].do_rst) do_reset();
            @(negedge ck);
            SV = vecs[k].sv; CL = vecs[k].cl; CN = vecs[k].cn; DE = vecs[k].de;
            ticks(vecs[k].n, vecs[k].clr);
            settle();
            chk({vecs[k].name, ".level"}, level, vecs[k].lvl);
            chk({vecs[k].name, ".temp"},  temp,  vecs[k].tmp);
            chk({vecs[k].name, ".SL"}, SL, vecs[k].sl);
            chk({vecs[k].name, ".SG"}, SG, vecs[k].sg);
            chk({vecs[k].name, ".LS"}, LS, vecs[k].ls);
            chk({vecs[k].name, ".LC"}, LC, vecs[k].lc);
            chk({vecs[k].name, ".SE"}, SE, vecs[k].se);
        end

        // Agitator: CN drop clears without a tick, then 9 ticks fall short
        @(negedge ck);
        CN = 1'b0;
        settle();
        chk("cn_drop.LC", LC, 0);
        @(negedge ck);
        CN = 1'b1;
        ticks(9, 1'b0);
        settle();
        chk("remix9.LC", LC, 0);
        ticks(1, 1'b0);
        settle();
        chk("remix10.LC", LC, 1);

        // State holds while tick stays low
        do_reset();
        @(negedge ck);
        SV = 1'b1;
        ticks(3, 1'b0);
        repeat (6) @(negedge ck);
        chk("no_tick.level", level, 12);

        // Start button synchronizer: two-ck latency, level follows
        @(negedge ck);
        m_btn = 1'b1;
        @(negedge ck);
        chk("m_lat1", M, 0);
        @(negedge ck);
        chk("m_lat2", M, 1);
        m_btn = 1'b0;
        @(negedge ck);
        chk("m_fall1", M, 1);
        @(negedge ck);
        chk("m_fall2", M, 0);

        // Mid-run reset discards state
        do_reset();
        @(negedge ck);
        chk("midrst.level", level, 0);
        chk("midrst.temp", temp, 25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
